// File: rtl/pcileech_sysctl.sv
// pcileech_sysctl: tick counter, debounced buttons, stretched system reset and
// heartbeat/activity LEDs. Optional LED dimming via PCILEECH_SYSCTL_LED_PWM_EN.
`default_nettype none

module pcileech_sysctl #(
    parameter int NUM_BTN         = 2,
    parameter int RST_BTN_IDX     = 1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RST_HOLD        = 16,
    parameter int NUM_ACT         = 2,
    parameter int STRETCH_CYCLES  = 10000000,
    parameter int HB_BIT          = 26,
    parameter int LED_DUTY        = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_db,
    output logic [NUM_BTN-1:0] btn_press,
    output logic               sys_rst,
    input  logic [NUM_ACT-1:0] act_in,
    input  logic               led_invert,
    output logic [63:0]        tickcount64,
    output logic [NUM_ACT:0]   led_out
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(RST_HOLD + 1);
    localparam int SW = $clog2(STRETCH_CYCLES + 1);

    if (NUM_BTN < 1 || NUM_BTN > 8 || RST_BTN_IDX < 0 || RST_BTN_IDX >= NUM_BTN ||
        DEBOUNCE_CYCLES < 2 || RST_HOLD < 1 || NUM_ACT < 1 || NUM_ACT > 8 ||
        STRETCH_CYCLES < 1 || HB_BIT < 0 || HB_BIT > 63 || LED_DUTY < 0) begin : g_param_check
        $error("pcileech_sysctl: parameter out of range");
    end

    logic [63:0]        tick_cnt;
    logic [NUM_BTN-1:0] btn_sync1;
    logic [NUM_BTN-1:0] btn_sync2;
    logic [HW-1:0]      hold_cnt;
    logic [NUM_ACT-1:0] act_raw;
    logic [NUM_ACT:0]   led_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt  <= '0;
            btn_sync1 <= '0;
            btn_sync2 <= '0;
        end else begin
            tick_cnt  <= tick_cnt + 64'd1;
            btn_sync1 <= btn_in;
            btn_sync2 <= btn_sync1;
        end
    end

    assign tickcount64 = tick_cnt;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        logic [DW-1:0] db_cnt;
        logic          db_q;
        logic          press_q;

        // btn_db only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_ff @(posedge clk) begin
            if (rst) begin
                db_cnt  <= '0;
                db_q    <= 1'b0;
                press_q <= 1'b0;
            end else if (btn_sync2[i] == db_q) begin
                db_cnt  <= '0;
                press_q <= 1'b0;
            end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt  <= '0;
                db_q    <= btn_sync2[i];
                press_q <= btn_sync2[i];
            end else begin
                db_cnt  <= db_cnt + DW'(1);
                press_q <= 1'b0;
            end
        end

        assign btn_db[i]    = db_q;
        assign btn_press[i] = press_q;
    end

    always_ff @(posedge clk) begin
        if (rst || btn_db[RST_BTN_IDX]) begin
            hold_cnt <= HW'(RST_HOLD);
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
        end
    end

    assign sys_rst = (hold_cnt != '0);

    for (genvar k = 0; k < NUM_ACT; k++) begin : g_act
        logic [SW-1:0] str_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                str_cnt <= '0;
            end else if (act_in[k]) begin
                str_cnt <= SW'(STRETCH_CYCLES);
            end else if (str_cnt != '0) begin
                str_cnt <= str_cnt - SW'(1);
            end
        end

        assign act_raw[k] = (str_cnt != '0);
    end

    // Reset still honours led_invert so inverted boards stay dark during reset.
    always_comb begin
        led_next = {act_raw ^ {NUM_ACT{led_invert}}, tick_cnt[HB_BIT] | (|btn_db)};
        if (rst) begin
            led_next = {{NUM_ACT{led_invert}}, 1'b0};
        end
    end

`ifdef PCILEECH_SYSCTL_LED_PWM_EN
    logic pwm_on;
    assign pwm_on = ({24'd0, tick_cnt[7:0]} < 32'(LED_DUTY));

    always_ff @(posedge clk) begin
        led_out <= led_next & {(NUM_ACT + 1){pwm_on}};
    end
`else
    always_ff @(posedge clk) begin
        led_out <= led_next;
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pcileech_sysctl.sv
// Directed, table-driven bench for pcileech_sysctl with small test parameters.
`default_nettype none

module tb_pcileech_sysctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  btn_in = 2'b00;
    logic [1:0]  btn_db;
    logic [1:0]  btn_press;
    logic        sys_rst;
    logic [1:0]  act_in = 2'b00;
    logic        led_invert = 1'b0;
    logic [63:0] tickcount64;
    logic [2:0]  led_out;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_tick  = 64'd0;
    logic [63:0] prev_tick = 64'd0;

    pcileech_sysctl #(
        .NUM_BTN(2), .RST_BTN_IDX(1), .DEBOUNCE_CYCLES(4), .RST_HOLD(3),
        .NUM_ACT(2), .STRETCH_CYCLES(5), .HB_BIT(3), .LED_DUTY(64)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .btn_db(btn_db), .btn_press(btn_press),
        .sys_rst(sys_rst), .act_in(act_in), .led_invert(led_invert),
        .tickcount64(tickcount64), .led_out(led_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock, update the tick model, and check the counter.
    task automatic step();
        @(posedge clk);
        prev_tick = exp_tick;
        exp_tick  = rst ? 64'd0 : exp_tick + 64'd1;
        #1;
        chk("tick", tickcount64, exp_tick);
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] act;
        logic       inv;
        logic [1:0] led21;
        logic       sys;
    } vec_t;

    vec_t tbl[24];

    initial begin
        int ones;
        tbl[0]  = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b1};
        tbl[1]  = '{1'b1, 2'b00, 1'b0, 2'b00, 1'b1};
        tbl[2]  = '{1'b0, 2'b01, 1'b0, 2'b00, 1'b1};
        tbl[3]  = '{1'b0, 2'b00, 1'b0, 2'b01, 1'b1};
        tbl[4]  = '{1'b0, 2'b00, 1'b0, 2'b01, 1'b0};
        tbl[5]  = '{1'b0, 2'b01, 1'b0, 2'b01, 1'b0};
        tbl[6]  = '{1'b0, 2'b00, 1'b0, 2'b01, 1'b0};
        tbl[7]  = '{1'b0, 2'b00, 1'b0, 2'b01, 1'b0};
        tbl[8]  = '{1'b0, 2'b00, 1'b0, 2'b01, 1'b0};
        tbl[9]  = '{1'b0, 2'b00, 1'b0, 2'b01, 1'b0};
        tbl[10] = '{1'b0, 2'b00, 1'b0, 2'b01, 1'b0};
        tbl[11] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
        tbl[12] = '{1'b0, 2'b00, 1'b1, 2'b11, 1'b0};
        tbl[13] = '{1'b0, 2'b10, 1'b1, 2'b11, 1'b0};
        tbl[14] = '{1'b0, 2'b00, 1'b1, 2'b01, 1'b0};
        tbl[15] = '{1'b0, 2'b00, 1'b1, 2'b01, 1'b0};
        tbl[16] = '{1'b0, 2'b00, 1'b1, 2'b01, 1'b0};
        tbl[17] = '{1'b0, 2'b00, 1'b1, 2'b01, 1'b0};
        tbl[18] = '{1'b0, 2'b00, 1'b1, 2'b01, 1'b0};
        tbl[19] = '{1'b0, 2'b00, 1'b1, 2'b11, 1'b0};
        tbl[20] = '{1'b1, 2'b11, 1'b1, 2'b11, 1'b1};
        tbl[21] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1};
        tbl[22] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1};
        tbl[23] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b0};

        // Reset, activity stretch, invert and post-reset hold.
        for (int i = 0; i < 24; i++) begin
            rst        = tbl[i].rst;
            act_in     = tbl[i].act;
            led_invert = tbl[i].inv;
            step();
            chk("tbl_led21", 64'(led_out[2:1]), 64'(tbl[i].led21));
            chk("tbl_sys_rst", 64'(sys_rst), 64'(tbl[i].sys));
            chk("tbl_btn_db", 64'(btn_db), 64'd0);
            chk("tbl_led0", 64'(led_out[0]), tbl[i].rst ? 64'd0 : 64'(prev_tick[3]));
        end
        act_in = 2'b00;
        led_invert = 1'b0;

        // Glitch of 3 cycles must be rejected.
        for (int n = 1; n <= 11; n++) begin
            btn_in = (n <= 3) ? 2'b01 : 2'b00;
            step();
            chk("glitch_db", 64'(btn_db), 64'd0);
            chk("glitch_press", 64'(btn_press), 64'd0);
        end

        // Button 0 held: debounced after 2 sync + 4 stable cycles.
        for (int n = 1; n <= 10; n++) begin
            btn_in = 2'b01;
            step();
            chk("press_db0", 64'(btn_db[0]), (n >= 6) ? 64'd1 : 64'd0);
            chk("press_pulse0", 64'(btn_press[0]), (n == 6) ? 64'd1 : 64'd0);
            chk("press_sys_rst", 64'(sys_rst), 64'd0);
            if (n >= 7) chk("press_led0", 64'(led_out[0]), 64'd1);
        end
        for (int m = 1; m <= 10; m++) begin
            btn_in = 2'b00;
            step();
            chk("release_db0", 64'(btn_db[0]), (m <= 5) ? 64'd1 : 64'd0);
            chk("release_pulse0", 64'(btn_press[0]), 64'd0);
        end

        // Reset button: hold while debounced, 3 cycles after, rst mid-hold restarts.
        for (int n = 1; n <= 22; n++) begin
            btn_in = (n <= 10) ? 2'b10 : 2'b00;
            rst    = (n == 18);
            step();
            chk("rbtn_db1", 64'(btn_db[1]), (n >= 6 && n <= 15) ? 64'd1 : 64'd0);
            chk("rbtn_pulse1", 64'(btn_press[1]), (n == 6) ? 64'd1 : 64'd0);
            chk("rbtn_sys_rst", 64'(sys_rst), (n >= 7 && n <= 20) ? 64'd1 : 64'd0);
        end
        rst = 1'b0;

        // Counter wrap from 2^64-2.
        force dut.tick_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.tick_cnt;
        exp_tick = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        chk("wrap_max", tickcount64, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        chk("wrap_zero", tickcount64, 64'd0);

        // Activity held high: constant on, or 64/256 duty when dimmed.
        act_in = 2'b01;
        step();
        step();
        ones = 0;
        for (int n = 0; n < 256; n++) begin
            step();
            ones += int'(led_out[1]);
`ifndef PCILEECH_SYSCTL_LED_PWM_EN
            chk("held_led1", 64'(led_out[1]), 64'd1);
`endif
        end
`ifdef PCILEECH_SYSCTL_LED_PWM_EN
        chk("pwm_on_count", 64'(ones), 64'd64);
`else
        chk("held_on_count", 64'(ones), 64'd256);
`endif
        act_in = 2'b00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
